consecutive_number: RTL and testbench

- Serial run-length detector: samples a 1-bit input stream `x` on each rising clock edge.
- Asserts `y` while the most recent RUN_LEN samples (default 3) have all been 1.
- Implemented as a Moore FSM with a saturating run counter.
- Used as a pattern/sequence-detect leaf block fed by a serial bit source.

---
 rtl/consecutive_number_if.sv | 13 +
 rtl/consecutive_number.sv | 53 +++++
 tb/tb_consecutive_number.sv | 139 +++++++++++++
 3 files changed

// File: rtl/consecutive_number_if.sv
// rtl/consecutive_number_if.sv - serial bit in / detect flag out bundle for consecutive_number
//
// Purpose: groups the serial data bit and the detect flag of the run-length detector.
// Signals:
//   x : serial data bit, driven by the bit source (master)
//   y : detect flag, driven by the detector (slave)
interface consecutive_number_if;
  logic x;
  logic y;

  modport master (output x, input y);
  modport slave  (input x, output y);
endinterface

// File: rtl/consecutive_number.sv
// rtl/consecutive_number.sv - serial run-length detector, flags RUN_LEN consecutive 1s
//
// Purpose: Moore FSM that samples bus.x on every rising clk edge and raises bus.y while
//          the most recent RUN_LEN samples were all 1. The state register is a saturating
//          run counter: value k means the last k samples were 1, value RUN_LEN is detect.
// Ports:
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset, forces S0 (y=0) immediately
//   bus.x    : serial data bit in
//   bus.y    : detect flag out, decoded from state only (no path from x)
// Parameters:
//   RUN_LEN  : consecutive 1s required, 2..15
//   CNT_W    : state register width, 2**CNT_W > RUN_LEN
module consecutive_number #(
  parameter int RUN_LEN = 3,
  parameter int CNT_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  consecutive_number_if.slave  bus
);

  localparam logic [CNT_W-1:0] S_IDLE = '0;
  localparam logic [CNT_W-1:0] S_DET  = CNT_W'(RUN_LEN);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = S_IDLE;
    if (cnt_q > S_DET) begin
      // Encodings above the detect state are unreachable; fall back to idle.
      cnt_d = S_IDLE;
    end else if (bus.x) begin
      // Saturate in the detect state so overlapping runs keep y high.
      cnt_d = (cnt_q == S_DET) ? S_DET : cnt_q + 1'b1;
    end else begin
      cnt_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= S_IDLE;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Exact compare keeps y low in every illegal encoding as well.
  assign bus.y = (cnt_q == S_DET);

endmodule

// File: tb/tb_consecutive_number.sv
// tb/tb_consecutive_number.sv - directed self-checking bench for consecutive_number
module tb_consecutive_number;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  consecutive_number_if a_if ();
  consecutive_number_if b_if ();

  consecutive_number #(.RUN_LEN(3), .CNT_W(4)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  consecutive_number #(.RUN_LEN(5), .CNT_W(4)) dut5 (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic observed, input logic expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic check_state(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive both inputs one time unit after an edge, then advance to 1 unit past the next edge.
  task automatic cyc(input logic xa, input logic xb);
    a_if.x = xa;
    b_if.x = xb;
    @(posedge clk);
    #1;
  endtask

  task automatic step_a(input logic xv, input logic exp, input string tag);
    cyc(xv, 1'b0);
    check(tag, a_if.y, exp);
  endtask

  task automatic step_b(input logic xv, input logic exp, input string tag);
    cyc(1'b0, xv);
    check(tag, b_if.y, exp);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    // Reset with unknown input
    rst    = 1'b1;
    a_if.x = 1'bx;
    b_if.x = 1'bx;
    #1;
    check("rst_async_y", a_if.y, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("rst_hold_y", a_if.y, 1'b0);
      check_state("rst_hold_state", dut3.cnt_q, 4'd0);
      check("rst_hold_y5", b_if.y, 1'b0);
    end
    rst    = 1'b0;
    a_if.x = 1'b0;
    b_if.x = 1'b0;
    for (int i = 0; i < 8; i++) step_a(1'b0, 1'b0, "idle_zeros");

    // Basic detect: exactly one cycle high
    step_a(1'b1, 1'b0, "basic_1st");
    step_a(1'b1, 1'b0, "basic_2nd");
    step_a(1'b1, 1'b1, "basic_3rd");
    step_a(1'b0, 1'b0, "basic_drop");

    // No false detect
    step_a(1'b1, 1'b0, "nofalse_0");
    step_a(1'b0, 1'b0, "nofalse_1");
    step_a(1'b1, 1'b0, "nofalse_2");
    step_a(1'b0, 1'b0, "nofalse_3");
    step_a(1'b1, 1'b0, "nofalse_4");
    step_a(1'b1, 1'b0, "nofalse_5");
    step_a(1'b0, 1'b0, "nofalse_6");

    // Overlap: six 1s give four high cycles
    step_a(1'b1, 1'b0, "ovl_1");
    step_a(1'b1, 1'b0, "ovl_2");
    step_a(1'b1, 1'b1, "ovl_3");
    step_a(1'b1, 1'b1, "ovl_4");
    step_a(1'b1, 1'b1, "ovl_5");
    step_a(1'b1, 1'b1, "ovl_6");
    step_a(1'b0, 1'b0, "ovl_drop");

    // Asynchronous reset mid-run, pulsed between edges
    step_a(1'b1, 1'b0, "arst_pre_1");
    step_a(1'b1, 1'b0, "arst_pre_2");
    step_a(1'b1, 1'b1, "arst_pre_3");
    step_a(1'b1, 1'b1, "arst_pre_4");
    #2;
    rst = 1'b1;
    #1;
    check("arst_y_no_edge", a_if.y, 1'b0);
    check_state("arst_state", dut3.cnt_q, 4'd0);
    #1;
    rst = 1'b0;
    step_a(1'b1, 1'b0, "arst_post_1");
    step_a(1'b1, 1'b0, "arst_post_2");
    step_a(1'b1, 1'b1, "arst_post_3");
    step_a(1'b0, 1'b0, "arst_post_drop");

    // RUN_LEN = 5 instance
    for (int i = 0; i < 4; i++) step_b(1'b1, 1'b0, "rl5_first4");
    step_b(1'b1, 1'b1, "rl5_5th");
    step_b(1'b0, 1'b0, "rl5_drop");
    for (int i = 0; i < 4; i++) step_b(1'b1, 1'b0, "rl5_four_a");
    step_b(1'b0, 1'b0, "rl5_break");
    for (int i = 0; i < 4; i++) step_b(1'b1, 1'b0, "rl5_four_b");
    step_b(1'b1, 1'b1, "rl5_five_b");
    step_b(1'b1, 1'b1, "rl5_six_b");
    step_b(1'b0, 1'b0, "rl5_end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
